// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : RAW-hazard and control-shadow stall unit placed between
//                fetch and the decode pipeline register. Tracks one countdown
//                counter per architectural register for in-flight writes,
//                plus a branch-shadow counter. Each cycle it either passes the
//                fetched instruction or injects NOP_INST and holds the PC.
//                Also provides forwarding distance, early branch release,
//                pipeline freeze, flush and a saturating stall counter.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in            clock
//    rst          in            asynchronous active-high reset
//    fetch_inst   in  INST_W    fetched instruction
//    fetch_valid  in  1         fetch_inst is valid
//    src1_reg     in  REG_W     first source register
//    src1_used    in  1         first source is read
//    src2_reg     in  REG_W     second source register
//    src2_used    in  1         second source is read
//    dst_reg      in  REG_W     destination register
//    dst_wr       in  1         instruction writes dst_reg
//    is_ctrl      in  1         jump or branch
//    pipe_hold    in  1         pipeline frozen this cycle
//    br_resolve   in  1         in-flight control instruction resolved
//    flush        in  1         synchronous clear of pending state
//    next_inst    out INST_W    instruction presented to decode
//    pc_nop       out 1         hold the PC
//    issue        out 1         fetch_inst accepted this cycle
//    busy_regs    out NUM_REGS  bit i set while register i has a pending write
//    stall_cycles out CNT_W     saturating count of hazard stall cycles
// ============================================================================
module hazard_scoreboard #(
  parameter int unsigned       INST_W     = 16,
  parameter int unsigned       NUM_REGS   = 8,
  parameter int unsigned       REG_W      = 3,
  parameter int unsigned       PIPE_DEPTH = 3,
  parameter int unsigned       FWD_DIST   = 0,
  parameter int unsigned       BR_SHADOW  = 4,
  parameter int unsigned       CNT_W      = 16,
  parameter logic [INST_W-1:0] NOP_INST   = 16'h0800
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INST_W-1:0]   fetch_inst,
  input  logic                fetch_valid,
  input  logic [REG_W-1:0]    src1_reg,
  input  logic [REG_W-1:0]    src2_reg,
  input  logic                src1_used,
  input  logic                src2_used,
  input  logic [REG_W-1:0]    dst_reg,
  input  logic                dst_wr,
  input  logic                is_ctrl,
  input  logic                pipe_hold,
  input  logic                br_resolve,
  input  logic                flush,
  output logic [INST_W-1:0]   next_inst,
  output logic                pc_nop,
  output logic                issue,
  output logic [NUM_REGS-1:0] busy_regs,
  output logic [CNT_W-1:0]    stall_cycles
);

  // Counter widths; kept at least one bit so degenerate depths still build.
  localparam int unsigned CW = (PIPE_DEPTH < 1) ? 1 : $clog2(PIPE_DEPTH + 1);
  localparam int unsigned SW = (BR_SHADOW  < 1) ? 1 : $clog2(BR_SHADOW + 1);

  localparam logic [CW-1:0] C_DEPTH   = CW'(PIPE_DEPTH);
  localparam logic [SW-1:0] C_SHADOW  = SW'(BR_SHADOW);
  localparam logic [31:0]   C_FWD     = 32'(FWD_DIST);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);
  localparam logic [SW-1:0] C_SH_ONE  = SW'(1);
  localparam logic [CNT_W-1:0] C_STALL_ONE = CNT_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CW-1:0]    r_cnt [NUM_REGS];
  logic [SW-1:0]    r_shadow;
  logic [CNT_W-1:0] r_stall;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  logic [31:0] w_src1_cnt;
  logic [31:0] w_src2_cnt;
  logic        w_data_hz;
  logic        w_ctrl_hz;
  logic        w_stall_sel;
  logic        w_issue;

  // Zero-extend so the forwarding threshold compares at full parameter width;
  // a FWD_DIST at or above PIPE_DEPTH then simply never raises a hazard.
  assign w_src1_cnt = {{(32-CW){1'b0}}, r_cnt[src1_reg]};
  assign w_src2_cnt = {{(32-CW){1'b0}}, r_cnt[src2_reg]};

  assign w_data_hz = (src1_used && (w_src1_cnt > C_FWD)) ||
                     (src2_used && (w_src2_cnt > C_FWD));
  assign w_ctrl_hz = (r_shadow != '0);

  // Hazard stall is only the lowest-priority NOP case: reset, flush, hold
  // and an empty fetch slot all take precedence and are not counted.
  assign w_stall_sel = !rst && !flush && !pipe_hold && fetch_valid &&
                       (w_ctrl_hz || w_data_hz);

  assign w_issue = !rst && !flush && !pipe_hold && fetch_valid &&
                   !w_ctrl_hz && !w_data_hz;

  // --------------------------------------------------------------------------
  // Output selection (priority order)
  // --------------------------------------------------------------------------
  always_comb begin
    next_inst = NOP_INST;
    pc_nop    = 1'b0;
    issue     = 1'b0;
    if (rst) begin
      pc_nop = 1'b1;
    end else if (flush) begin
      pc_nop = 1'b0;
    end else if (pipe_hold) begin
      pc_nop = 1'b1;
    end else if (!fetch_valid) begin
      pc_nop = 1'b0;
    end else if (w_ctrl_hz || w_data_hz) begin
      pc_nop = 1'b1;
    end else begin
      next_inst = fetch_inst;
      issue     = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard, shadow and stall counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
      r_shadow <= '0;
      r_stall  <= '0;
    end else if (flush) begin
      // Pending writes and the shadow are discarded; the statistic survives.
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
      r_shadow <= '0;
    end else if (!pipe_hold) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // A new write restarts the countdown even if the register is busy.
        if (w_issue && dst_wr && (dst_reg == REG_W'(i))) begin
          r_cnt[i] <= C_DEPTH;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - C_CNT_ONE;
        end
      end

      if (w_issue && is_ctrl) begin
        r_shadow <= C_SHADOW;
      end else if (br_resolve) begin
        r_shadow <= '0;
      end else if (r_shadow != '0) begin
        r_shadow <= r_shadow - C_SH_ONE;
      end

      if (w_stall_sel && !(&r_stall)) begin
        r_stall <= r_stall + C_STALL_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Status outputs
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_busy
    assign busy_regs[g] = (r_cnt[g] != '0);
  end

  assign stall_cycles = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Directed self-checking bench for hazard_scoreboard. Three
//                instances share stimulus: default build, FWD_DIST = 1 build
//                and CNT_W = 2 build (stall counter saturation).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic [15:0] fetch_inst;
  logic        fetch_valid;
  logic [2:0]  src1_reg, src2_reg, dst_reg;
  logic        src1_used, src2_used, dst_wr, is_ctrl;
  logic        pipe_hold, br_resolve, flush;

  logic [15:0] d_next, f_next, s_next;
  logic        d_pcnop, f_pcnop, s_pcnop;
  logic        d_issue, f_issue, s_issue;
  logic [7:0]  d_busy, f_busy, s_busy;
  logic [15:0] d_stall, f_stall;
  logic [1:0]  s_stall;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard u_dut (
    .clk(clk), .rst(rst), .fetch_inst(fetch_inst), .fetch_valid(fetch_valid),
    .src1_reg(src1_reg), .src2_reg(src2_reg), .src1_used(src1_used),
    .src2_used(src2_used), .dst_reg(dst_reg), .dst_wr(dst_wr),
    .is_ctrl(is_ctrl), .pipe_hold(pipe_hold), .br_resolve(br_resolve),
    .flush(flush), .next_inst(d_next), .pc_nop(d_pcnop), .issue(d_issue),
    .busy_regs(d_busy), .stall_cycles(d_stall)
  );

  hazard_scoreboard #(.FWD_DIST(1)) u_fwd (
    .clk(clk), .rst(rst), .fetch_inst(fetch_inst), .fetch_valid(fetch_valid),
    .src1_reg(src1_reg), .src2_reg(src2_reg), .src1_used(src1_used),
    .src2_used(src2_used), .dst_reg(dst_reg), .dst_wr(dst_wr),
    .is_ctrl(is_ctrl), .pipe_hold(pipe_hold), .br_resolve(br_resolve),
    .flush(flush), .next_inst(f_next), .pc_nop(f_pcnop), .issue(f_issue),
    .busy_regs(f_busy), .stall_cycles(f_stall)
  );

  hazard_scoreboard #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .fetch_inst(fetch_inst), .fetch_valid(fetch_valid),
    .src1_reg(src1_reg), .src2_reg(src2_reg), .src1_used(src1_used),
    .src2_used(src2_used), .dst_reg(dst_reg), .dst_wr(dst_wr),
    .is_ctrl(is_ctrl), .pipe_hold(pipe_hold), .br_resolve(br_resolve),
    .flush(flush), .next_inst(s_next), .pc_nop(s_pcnop), .issue(s_issue),
    .busy_regs(s_busy), .stall_cycles(s_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] inst,
                       input logic [2:0] s1, input logic s1u,
                       input logic [2:0] s2, input logic s2u,
                       input logic [2:0] d, input logic dw, input logic ctrl);
    fetch_valid = v;   fetch_inst = inst;
    src1_reg    = s1;  src1_used  = s1u;
    src2_reg    = s2;  src2_used  = s2u;
    dst_reg     = d;   dst_wr     = dw;
    is_ctrl     = ctrl;
    pipe_hold   = 1'b0; br_resolve = 1'b0; flush = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- Reset ----------------
    rst = 1'b1;
    drive(1, 16'hD94C, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_next",  32'(d_next),  32'h0800);
    chk("rst_pcnop", 32'(d_pcnop), 1);
    chk("rst_issue", 32'(d_issue), 0);
    chk("rst_busy",  32'(d_busy),  0);
    chk("rst_stall", 32'(d_stall), 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rel_next",  32'(d_next),  32'hD94C);
    chk("rel_issue", 32'(d_issue), 1);
    chk("rel_pcnop", 32'(d_pcnop), 0);

    // ---------------- RAW, no forwarding / FWD_DIST=1 ----------------
    next_cycle();
    drive(1, 16'hA001, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    chk("raw_prod_issue", 32'(d_issue), 1);
    next_cycle();
    drive(1, 16'hB002, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("raw_stall_pcnop", 32'(d_pcnop), 1);
      chk("raw_stall_next",  32'(d_next),  32'h0800);
      chk("raw_stall_busy",  32'(d_busy),  32'h02);
      chk("fwd_issue",       32'(f_issue), (i == 3) ? 1 : 0);
      next_cycle();
    end
    @(negedge clk);
    chk("raw_cons_issue", 32'(d_issue), 1);
    chk("raw_cons_next",  32'(d_next),  32'hB002);
    chk("raw_busy_clr",   32'(d_busy),  0);
    chk("raw_stall_cnt",  32'(d_stall), 3);
    chk("fwd_stall_cnt",  32'(f_stall), 2);
    chk("sat_stall_cnt",  32'(s_stall), 3);

    // ---------------- Branch shadow ----------------
    next_cycle();
    drive(1, 16'hC003, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("br_issue", 32'(d_issue), 1);
    next_cycle();
    drive(1, 16'hC004, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("br_shadow_pcnop", 32'(d_pcnop), 1);
      chk("br_shadow_issue", 32'(d_issue), 0);
      next_cycle();
    end
    @(negedge clk);
    chk("br_after_issue", 32'(d_issue), 1);
    chk("br_stall_cnt",   32'(d_stall), 7);

    // Early resolve in cycle 2 -> issue in cycle 3
    next_cycle();
    drive(1, 16'hC005, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("brr_issue", 32'(d_issue), 1);
    next_cycle();
    drive(1, 16'hC006, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("brr_c1_issue", 32'(d_issue), 0);
    next_cycle();
    br_resolve = 1'b1;
    @(negedge clk);
    chk("brr_c2_issue", 32'(d_issue), 0);
    next_cycle();
    br_resolve = 1'b0;
    @(negedge clk);
    chk("brr_c3_issue", 32'(d_issue), 1);
    chk("brr_stall_cnt", 32'(d_stall), 9);
    chk("sat_hold_3",    32'(s_stall), 3);

    // ---------------- Pipe hold ----------------
    next_cycle();
    drive(1, 16'hA202, 0, 0, 0, 0, 2, 1, 0);
    @(negedge clk);
    chk("hold_prod_issue", 32'(d_issue), 1);
    next_cycle();
    drive(1, 16'hB203, 2, 1, 0, 0, 0, 0, 0);
    pipe_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_pcnop", 32'(d_pcnop), 1);
      chk("hold_issue", 32'(d_issue), 0);
      chk("hold_busy",  32'(d_busy),  32'h04);
      chk("hold_stall", 32'(d_stall), 9);
      next_cycle();
    end
    pipe_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_rel_issue", 32'(d_issue), 0);
      chk("hold_rel_pcnop", 32'(d_pcnop), 1);
      next_cycle();
    end
    @(negedge clk);
    chk("hold_cons_issue", 32'(d_issue), 1);
    chk("hold_stall_cnt",  32'(d_stall), 12);

    // ---------------- Flush during stall ----------------
    next_cycle();
    drive(1, 16'hC505, 0, 0, 0, 0, 5, 1, 1);
    @(negedge clk);
    chk("fl_prod_issue", 32'(d_issue), 1);
    next_cycle();
    drive(1, 16'hB506, 5, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("fl_stall_issue", 32'(d_issue), 0);
    chk("fl_stall_busy",  32'(d_busy),  32'h20);
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    chk("fl_pcnop", 32'(d_pcnop), 0);
    chk("fl_issue", 32'(d_issue), 0);
    chk("fl_next",  32'(d_next),  32'h0800);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_busy_clr",  32'(d_busy),  0);
    chk("fl_cons_issue", 32'(d_issue), 1);
    chk("fl_stall_kept", 32'(d_stall), 13);

    // ---------------- Re-write and saturation ----------------
    next_cycle();
    drive(1, 16'hA307, 0, 0, 0, 0, 3, 1, 0);
    @(negedge clk);
    chk("rw_first_issue", 32'(d_issue), 1);
    next_cycle();
    drive(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("rw_busy",  32'(d_busy),  32'h08);
      chk("rw_pcnop", 32'(d_pcnop), 0);
      next_cycle();
    end
    drive(1, 16'hA308, 0, 0, 0, 0, 3, 1, 0);
    @(negedge clk);
    chk("rw_c4_busy",  32'(d_busy),  0);
    chk("rw_c4_issue", 32'(d_issue), 1);
    next_cycle();
    drive(1, 16'hB309, 0, 0, 3, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rw_cons_busy",  32'(d_busy),  32'h08);
      chk("rw_cons_stall", 32'(d_issue), 0);
      next_cycle();
    end
    @(negedge clk);
    chk("rw_cons_issue", 32'(d_issue), 1);
    chk("rw_stall_cnt",  32'(d_stall), 16);
    chk("sat_final",     32'(s_stall), 3);

    // ---------------- Reset mid-stall ----------------
    next_cycle();
    drive(1, 16'hA40A, 0, 0, 0, 0, 4, 1, 0);
    @(negedge clk);
    chk("mr_prod_issue", 32'(d_issue), 1);
    next_cycle();
    drive(1, 16'hB40B, 4, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mr_stall_issue", 32'(d_issue), 0);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_busy",  32'(d_busy),  0);
    chk("mr_stall", 32'(d_stall), 0);
    chk("mr_pcnop", 32'(d_pcnop), 1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_rel_issue", 32'(d_issue), 1);
    chk("mr_rel_next",  32'(d_next),  32'hB40B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised RAW-hazard and control-shadow stall unit. It sits between fetch and the decode pipeline register. It keeps a per-register countdown scoreboard of in-flight writes and a branch-shadow counter. Each cycle it either passes the fetched instruction or injects `NOP_INST` and holds the PC. It adds configurable pipeline depth, optional forwarding distance, early branch release, pipeline freeze, flush and a stall-cycle counter.

## Interface
- `INST_W`, 16: instruction width.
- `NUM_REGS`, 8: architectural register count.
- `REG_W`, 3: register index width; must equal clog2(`NUM_REGS`).
- `PIPE_DEPTH`, 3: cycles a write stays pending after issue (D, X, M); the register file is write-through at W.
- `FWD_DIST`, 0: a consumer may issue once the producer count is ≤ `FWD_DIST`; 0 means no forwarding.
- `BR_SHADOW`, 4: bubble cycles after a control instruction issues.
- `CNT_W`, 16: stall counter width.
- `NOP_INST`, 16'h0800: injected bubble encoding.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `fetch_inst` in `INST_W`: fetched instruction.
- `fetch_valid` in 1: `fetch_inst` is valid.
- `src1_reg`, `src2_reg` in `REG_W` each: decoded source registers.
- `src1_used`, `src2_used` in 1 each: source is read.
- `dst_reg` in `REG_W`: destination register.
- `dst_wr` in 1: instruction writes `dst_reg`.
- `is_ctrl` in 1: jump or branch.
- `pipe_hold` in 1: pipeline frozen this cycle.
- `br_resolve` in 1: the in-flight control instruction has resolved.
- `flush` in 1: synchronous clear of all pending state.
- `next_inst` out `INST_W`: instruction presented to the decode register.
- `pc_nop` out 1: hold the PC.
- `issue` out 1: `fetch_inst` accepted this cycle.
- `busy_regs` out `NUM_REGS`: bit i is set when cnt[i] ≠ 0.
- `stall_cycles` out `CNT_W`: saturating count of hazard stall cycles.

## Operation
- State:
  - cnt[i], i < `NUM_REGS`, each ceil(log2(`PIPE_DEPTH`+1)) bits.
  - `shadow`, ceil(log2(`BR_SHADOW`+1)) bits.
  - `stall_cycles`.
- Combinational hazard terms:
  - `data_hz` = (src1_used && cnt[src1_reg] > FWD_DIST) || (src2_used && cnt[src2_reg] > FWD_DIST).
  - `ctrl_hz` = (shadow ≠ 0).
- Output priority (first match wins):
  1. `rst`: next_inst = NOP_INST, pc_nop = 1, issue = 0.
  2. `flush`: NOP, pc_nop = 0, issue = 0.
  3. `pipe_hold`: NOP, pc_nop = 1, issue = 0.
  4. `!fetch_valid`: NOP, pc_nop = 0, issue = 0.
  5. `ctrl_hz || data_hz`: NOP, pc_nop = 1, issue = 0.
  6. Otherwise: next_inst = fetch_inst, pc_nop = 0, issue = 1.
- Sequential update (edge, `rst` low):
  - `flush`: all cnt and `shadow` go to 0; `stall_cycles` is kept.
  - `pipe_hold` (and no `flush`): all state holds.
  - Otherwise:
    - Every nonzero cnt decrements by 1.
    - If issue && dst_wr, cnt[dst_reg] is set to PIPE_DEPTH. This overrides the decrement and covers re-writing an already-busy register.
    - `shadow`: if issue && is_ctrl, set to BR_SHADOW. Else if br_resolve, set to 0. Else if nonzero, decrement.
    - `br_resolve` with shadow = 0 and no ctrl issue has no effect.
    - `stall_cycles` increments when rule 5 selected the output, and saturates at all-ones.
- A control instruction is itself subject to `data_hz` (e.g. a register jump on a busy Rs).
- A stalled instruction never updates cnt or `shadow`.

## Timing
- Outputs are combinational from inputs and state; state updates on the rising edge.
- Asynchronous reset clears all cnt, `shadow` and `stall_cycles` to 0. While reset is held: next_inst = NOP_INST, pc_nop = 1, issue = 0, busy_regs = 0.
- Producer issued in cycle t (defaults): cnt = 3, 2, 1 in cycles t+1, t+2, t+3 and 0 in t+4.
  - A dependent consumer with `FWD_DIST`=0 stalls in t+1..t+3 and issues in t+4.
  - With `FWD_DIST`=1 it issues in t+3.
- Control instruction issued in cycle t: bubbles in t+1..t+`BR_SHADOW`; the next instruction issues at t+`BR_SHADOW`+1 at the earliest.
  - `br_resolve` in cycle t+k allows issue in t+k+1.
- `pipe_hold` cycles do not count toward latency; counts resume after the hold.
- Reset deasserting mid-stall restarts from an empty scoreboard.

## Test plan
- Reset: assert rst with fetch_valid = 1 and fetch_inst = 16'hD94C -> next_inst = 16'h0800, pc_nop = 1, busy_regs = 0, stall_cycles = 0. Release rst -> next_inst = 16'hD94C, issue = 1.
- RAW, no forwarding: issue a write of r1 in cycle 0, then present src1 = r1 -> 3 stall cycles with pc_nop = 1, issue in cycle 4, stall_cycles = 3. Rebuild with FWD_DIST = 1 -> 2 stalls.
- Branch shadow: issue is_ctrl in cycle 0 -> NOP in cycles 1–4, issue in cycle 5. Repeat with br_resolve in cycle 2 -> issue in cycle 3.
- Hold: write r2 (cnt = 3), assert pipe_hold for 5 cycles -> busy_regs[2] stays 1, cnt unchanged, stall_cycles unchanged. After release, the consumer of r2 issues 3 cycles later.
- Flush during stall: cnt[5] = 2 and shadow = 3, assert flush -> next cycle busy_regs = 0 and a dependent instruction issues immediately; stall_cycles is kept.
- Re-write and saturation: write r3 in cycle 0 and again in cycle 4 (cnt[3] = 0 at cycle 4) -> cnt[3] = 3 in cycle 5. Back-to-back hazards with CNT_W = 2 -> stall_cycles saturates at 3.
